// File: rtl/seq_match_logger.sv
// Match logger: counts detector hits, timestamps each against a free-running
// cycle counter and queues the timestamps in a small FIFO with a valid/ready read port.
module seq_match_logger #(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned TS_W  = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     en,
  input  logic                     det_in,
  input  logic                     rd_ready,
  output logic                     rd_valid,
  output logic [TS_W-1:0]          rd_ts,
  output logic [$clog2(DEPTH):0]   level,
  output logic [CNT_W-1:0]         match_cnt,
  output logic                     cnt_sat,
  output logic                     ovf
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [TS_W-1:0]  ts;
  logic [TS_W-1:0]  mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    count;
  logic [CNT_W-1:0] cnt_inc;
  logic             evt;
  logic             pop;
  logic             full;
  logic             push;

  assign evt     = det_in & en;
  assign rd_valid = (count != '0);
  assign pop     = rd_valid & rd_ready;
  assign full    = (count == LW'(DEPTH));
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push    = evt & (~full | pop);
  assign cnt_inc = match_cnt + CNT_W'(1);
  assign level   = count;
  assign rd_ts   = rd_valid ? mem[rd_ptr] : '0;

  // Timestamp, pointers, occupancy, match counter and sticky flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ts        <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      match_cnt <= '0;
      cnt_sat   <= 1'b0;
      ovf       <= 1'b0;
    end else if (clr) begin
      ts        <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      match_cnt <= '0;
      cnt_sat   <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      ts <= ts + TS_W'(1);
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
      if (evt & full & ~pop) ovf <= 1'b1;
      // Counter holds at all-ones; the flag rises on the edge it gets there.
      if (evt && (match_cnt != '1)) begin
        match_cnt <= cnt_inc;
        if (cnt_inc == '1) cnt_sat <= 1'b1;
      end
    end
  end

  // Storage needs no reset: contents are masked until pointers mark them valid.
  always_ff @(posedge clk) begin
    if (push & ~clr) mem[wr_ptr] <= ts;
  end

endmodule

// File: tb/tb_seq_match_logger.sv
// Self-checking bench for seq_match_logger: directed scenarios plus a randomized
// run compared against a queue-based model of the counting/timestamping rules.
module tb_seq_match_logger;

  localparam int unsigned CNT_W = 4;
  localparam int unsigned TS_W  = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned LW    = $clog2(DEPTH) + 1;
  localparam int          MAXC  = (1 << CNT_W) - 1;
  localparam int          TSMOD = 1 << TS_W;

  logic             clk = 1'b0;
  logic             rst;
  logic             clr;
  logic             en;
  logic             det_in;
  logic             rd_ready;
  logic             rd_valid;
  logic [TS_W-1:0]  rd_ts;
  logic [LW-1:0]    level;
  logic [CNT_W-1:0] match_cnt;
  logic             cnt_sat;
  logic             ovf;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int q[$];
  int mts;
  int mcnt;
  bit msat;
  bit movf;

  seq_match_logger #(.CNT_W(CNT_W), .TS_W(TS_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .clr(clr), .en(en), .det_in(det_in),
    .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_ts(rd_ts), .level(level),
    .match_cnt(match_cnt), .cnt_sat(cnt_sat), .ovf(ovf)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    q.delete();
    mts  = 0;
    mcnt = 0;
    msat = 1'b0;
    movf = 1'b0;
  endfunction

  // Apply one clock edge to the model using the current inputs, then advance the DUT.
  task automatic tick();
    bit ev;
    bit popd;
    bit was_full;
    if (rst || clr) begin
      model_reset();
    end else begin
      ev       = det_in && en;
      was_full = (q.size() == DEPTH);
      popd     = (q.size() > 0) && rd_ready;
      if (popd) void'(q.pop_front());
      if (ev) begin
        if (was_full && !popd) movf = 1'b1;
        else q.push_back(mts);
        if (mcnt < MAXC) mcnt++;
        if (mcnt == MAXC) msat = 1'b1;
      end
      mts = (mts + 1) % TSMOD;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    clr = 0; en = 1; det_in = 0; rd_ready = 0;
  endtask

  task automatic do_clr();
    idle_inputs();
    clr = 1;
    tick();
    clr = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    idle_inputs();
    det_in = 1;
    tick();
    tick();
    checks++;
    if ({rd_valid, level, match_cnt, cnt_sat, ovf, rd_ts} !== '0) begin
      errors++;
      $display("FAIL reset_state: v=%b lvl=%0d cnt=%0d sat=%b ovf=%b ts=%0d, want all 0",
               rd_valid, level, match_cnt, cnt_sat, ovf, rd_ts);
    end
    rst = 0;
    det_in = 0;
    model_reset();
  endtask

  task automatic test_basic_order();
    int exp_ts[3] = '{5, 9, 13};
    do_clr();
    for (int k = 0; k <= 13; k++) begin
      det_in = (k == 5 || k == 9 || k == 13);
      tick();
    end
    det_in = 0;
    checks++;
    if (level !== LW'(3) || match_cnt !== CNT_W'(3) || rd_ts !== TS_W'(5)) begin
      errors++;
      $display("FAIL basic_fill: lvl=%0d cnt=%0d ts=%0d, want 3 3 5", level, match_cnt, rd_ts);
    end
    tick();
    tick();
    checks++;
    if (rd_ts !== TS_W'(5) || rd_valid !== 1'b1) begin
      errors++;
      $display("FAIL head_stable: ts=%0d v=%b, want 5 1", rd_ts, rd_valid);
    end
    rd_ready = 1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (rd_ts !== TS_W'(exp_ts[i])) begin
        errors++;
        $display("FAIL basic_pop%0d: ts=%0d, want %0d", i, rd_ts, exp_ts[i]);
      end
      tick();
    end
    checks++;
    if (level !== '0 || rd_valid !== 1'b0 || rd_ts !== '0) begin
      errors++;
      $display("FAIL basic_drain: lvl=%0d v=%b ts=%0d, want 0 0 0", level, rd_valid, rd_ts);
    end
    rd_ready = 0;
  endtask

  task automatic test_overflow();
    do_clr();
    det_in = 1;
    for (int k = 0; k < 6; k++) tick();
    det_in = 0;
    checks++;
    if (level !== LW'(4) || match_cnt !== CNT_W'(6) || ovf !== 1'b1) begin
      errors++;
      $display("FAIL overflow: lvl=%0d cnt=%0d ovf=%b, want 4 6 1", level, match_cnt, ovf);
    end
    rd_ready = 1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rd_ts !== TS_W'(i)) begin
        errors++;
        $display("FAIL ovf_contents%0d: ts=%0d, want %0d", i, rd_ts, i);
      end
      tick();
    end
    checks++;
    if (ovf !== 1'b1 || rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL ovf_sticky: ovf=%b v=%b, want 1 0", ovf, rd_valid);
    end
    rd_ready = 0;
  endtask

  task automatic test_full_push_pop();
    do_clr();
    det_in = 1;
    for (int k = 0; k < 4; k++) tick();
    rd_ready = 1;
    tick();
    det_in = 0;
    rd_ready = 0;
    checks++;
    if (level !== LW'(4) || ovf !== 1'b0 || rd_ts !== TS_W'(1)) begin
      errors++;
      $display("FAIL full_push_pop: lvl=%0d ovf=%b ts=%0d, want 4 0 1", level, ovf, rd_ts);
    end
    rd_ready = 1;
    for (int i = 1; i <= 4; i++) begin
      checks++;
      if (rd_ts !== TS_W'(i)) begin
        errors++;
        $display("FAIL full_tail%0d: ts=%0d, want %0d", i, rd_ts, i);
      end
      tick();
    end
    rd_ready = 0;
  endtask

  task automatic test_saturation();
    do_clr();
    det_in = 1;
    rd_ready = 1;
    for (int n = 1; n <= 16; n++) begin
      tick();
      if (n >= 14) begin
        checks++;
        if (match_cnt !== CNT_W'((n < MAXC) ? n : MAXC) || cnt_sat !== (n >= MAXC)) begin
          errors++;
          $display("FAIL saturation_ev%0d: cnt=%0d sat=%b, want %0d %b", n, match_cnt, cnt_sat,
                   (n < MAXC) ? n : MAXC, n >= MAXC);
        end
      end
    end
    det_in = 0;
    rd_ready = 0;
  endtask

  task automatic test_enable_and_clr();
    do_clr();
    det_in = 1;
    tick();
    tick();
    en = 0;
    for (int k = 0; k < 5; k++) begin
      det_in = k[0];
      tick();
    end
    checks++;
    if (match_cnt !== CNT_W'(2) || level !== LW'(2) || rd_ts !== TS_W'(0)) begin
      errors++;
      $display("FAIL en_low: cnt=%0d lvl=%0d ts=%0d, want 2 2 0", match_cnt, level, rd_ts);
    end
    en = 1;
    det_in = 1;
    clr = 1;
    tick();
    clr = 0;
    checks++;
    if (match_cnt !== '0 || level !== '0 || rd_valid !== 1'b0 || cnt_sat !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL clr_with_event: cnt=%0d lvl=%0d v=%b sat=%b ovf=%b, want all 0",
               match_cnt, level, rd_valid, cnt_sat, ovf);
    end
    tick();
    det_in = 0;
    checks++;
    if (rd_ts !== TS_W'(0) || level !== LW'(1)) begin
      errors++;
      $display("FAIL ts_after_clr: ts=%0d lvl=%0d, want 0 1", rd_ts, level);
    end
  endtask

  task automatic test_ts_wrap();
    do_clr();
    for (int k = 0; k < TSMOD - 1; k++) tick();
    det_in = 1;
    tick();
    tick();
    det_in = 0;
    rd_ready = 1;
    checks++;
    if (rd_ts !== TS_W'(TSMOD - 1)) begin
      errors++;
      $display("FAIL wrap_last: ts=%0d, want %0d", rd_ts, TSMOD - 1);
    end
    tick();
    checks++;
    if (rd_ts !== TS_W'(0)) begin
      errors++;
      $display("FAIL wrap_zero: ts=%0d, want 0", rd_ts);
    end
    tick();
    rd_ready = 0;
  endtask

  task automatic test_async_reset();
    do_clr();
    det_in = 1;
    tick();
    tick();
    det_in = 0;
    #2 rst = 1;
    #1;
    checks++;
    if ({rd_valid, level, match_cnt, cnt_sat, ovf, rd_ts} !== '0) begin
      errors++;
      $display("FAIL async_reset: v=%b lvl=%0d cnt=%0d ts=%0d, want all 0",
               rd_valid, level, match_cnt, rd_ts);
    end
    #1 rst = 0;
    model_reset();
    det_in = 1;
    tick();
    det_in = 0;
    checks++;
    if (rd_ts !== TS_W'(0) || match_cnt !== CNT_W'(1)) begin
      errors++;
      $display("FAIL ts_restart: ts=%0d cnt=%0d, want 0 1", rd_ts, match_cnt);
    end
  endtask

  task automatic test_random();
    do_clr();
    for (int i = 0; i < 600; i++) begin
      clr      = ($urandom_range(0, 49) == 0);
      en       = ($urandom_range(0, 4) != 0);
      det_in   = $urandom_range(0, 1);
      rd_ready = ($urandom_range(0, 2) == 0);
      tick();
      checks++;
      if (level !== LW'(q.size()) || rd_valid !== (q.size() > 0) ||
          rd_ts !== TS_W'((q.size() > 0) ? q[0] : 0) || match_cnt !== CNT_W'(mcnt) ||
          cnt_sat !== msat || ovf !== movf) begin
        errors++;
        $display("FAIL random_cyc%0d: lvl=%0d v=%b ts=%0d cnt=%0d sat=%b ovf=%b, want %0d %b %0d %0d %b %b",
                 i, level, rd_valid, rd_ts, match_cnt, cnt_sat, ovf, q.size(), q.size() > 0,
                 (q.size() > 0) ? q[0] : 0, mcnt, msat, movf);
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_basic_order();
    test_overflow();
    test_full_push_pop();
    test_saturation();
    test_enable_and_clr();
    test_ts_wrap();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
